// File: rtl/argmax_unit.sv
// Final classification stage: captures ten signed class scores on a start strobe,
// scans them one per cycle and reports the index and value of the largest score.
module argmax_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  argmax_enable,
    input  logic [DATA_WIDTH-1:0] prob_0,
    input  logic [DATA_WIDTH-1:0] prob_1,
    input  logic [DATA_WIDTH-1:0] prob_2,
    input  logic [DATA_WIDTH-1:0] prob_3,
    input  logic [DATA_WIDTH-1:0] prob_4,
    input  logic [DATA_WIDTH-1:0] prob_5,
    input  logic [DATA_WIDTH-1:0] prob_6,
    input  logic [DATA_WIDTH-1:0] prob_7,
    input  logic [DATA_WIDTH-1:0] prob_8,
    input  logic [DATA_WIDTH-1:0] prob_9,
    output logic [3:0]            result,
    output logic [DATA_WIDTH-1:0] max_score,
    output logic                  argmax_done,
    output logic                  argmax_busy,
    output logic [1:0]            dbg_state
);

    // Handshake: argmax_enable acts as a valid strobe and ~argmax_busy as ready.
    // A start is accepted only on an edge where both are high; prob_* are captured
    // on that edge and never sampled again. argmax_done pulses for one cycle when
    // result/max_score take their new values.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd9;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] score [0:9];
    logic [DATA_WIDTH-1:0] best;
    logic [3:0]            best_idx;
    logic [3:0]            idx;

    logic [DATA_WIDTH-1:0] cur_score;
    logic [DATA_WIDTH-1:0] best_nxt;
    logic [3:0]            best_idx_nxt;
    logic                  scan_last;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (argmax_enable) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (scan_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Explicit mux keeps out-of-range idx values from indexing past the array.
    always_comb begin
        cur_score = score[0];
        case (idx)
            4'd1:    cur_score = score[1];
            4'd2:    cur_score = score[2];
            4'd3:    cur_score = score[3];
            4'd4:    cur_score = score[4];
            4'd5:    cur_score = score[5];
            4'd6:    cur_score = score[6];
            4'd7:    cur_score = score[7];
            4'd8:    cur_score = score[8];
            4'd9:    cur_score = score[9];
            default: cur_score = score[0];
        endcase
    end

    // Strict signed compare so the earliest index wins a tie.
    always_comb begin
        best_nxt     = best;
        best_idx_nxt = best_idx;
        if ($signed(cur_score) > $signed(best)) begin
            best_nxt     = cur_score;
            best_idx_nxt = idx;
        end
    end

    assign scan_last = (state == SCAN) && (idx == LAST_IDX);

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 10; i++) begin
                score[i] <= '0;
            end
            best      <= '0;
            best_idx  <= '0;
            idx       <= '0;
            result    <= '0;
            max_score <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (argmax_enable) begin
                        score[0] <= prob_0;
                        score[1] <= prob_1;
                        score[2] <= prob_2;
                        score[3] <= prob_3;
                        score[4] <= prob_4;
                        score[5] <= prob_5;
                        score[6] <= prob_6;
                        score[7] <= prob_7;
                        score[8] <= prob_8;
                        score[9] <= prob_9;
                        best     <= prob_0;
                        best_idx <= 4'd0;
                        idx      <= 4'd1;
                    end
                end
                SCAN: begin
                    best     <= best_nxt;
                    best_idx <= best_idx_nxt;
                    if (scan_last) begin
                        // Publish including the idx-9 compare from this same edge.
                        result    <= best_idx_nxt;
                        max_score <= best_nxt;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign argmax_done = (state == DONE);
    assign argmax_busy = (state != IDLE);
    assign dbg_state   = state;

endmodule

// File: tb/tb_argmax_unit.sv
// Self-checking bench for argmax_unit: a reference argmax model feeds an
// expected-result queue that a negedge monitor drains whenever argmax_done fires.
module tb_argmax_unit;

    localparam int W = 32;
    typedef logic [W-1:0] score_arr_t [10];

    logic         clk;
    logic         rst;
    logic         argmax_enable;
    logic [W-1:0] prob [10];
    logic [3:0]   result;
    logic [W-1:0] max_score;
    logic         argmax_done;
    logic         argmax_busy;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic prev_done = 1'b0;

    logic [3:0]   exp_q[$];
    logic [W-1:0] exp_max_q[$];
    int           exp_cyc_q[$];

    argmax_unit #(.DATA_WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .argmax_enable (argmax_enable),
        .prob_0        (prob[0]),
        .prob_1        (prob[1]),
        .prob_2        (prob[2]),
        .prob_3        (prob[3]),
        .prob_4        (prob[4]),
        .prob_5        (prob[5]),
        .prob_6        (prob[6]),
        .prob_7        (prob[7]),
        .prob_8        (prob[8]),
        .prob_9        (prob[9]),
        .result        (result),
        .max_score     (max_score),
        .argmax_done   (argmax_done),
        .argmax_busy   (argmax_busy),
        .dbg_state     (dbg_state)
    );

    // Clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void ref_argmax(input score_arr_t s, output logic [3:0] bi,
                                       output logic [W-1:0] bm);
        bi = 4'd0;
        bm = s[0];
        for (int i = 1; i < 10; i++) begin
            if ($signed(s[i]) > $signed(bm)) begin
                bi = 4'(i);
                bm = s[i];
            end
        end
    endfunction

    task automatic set_probs(input score_arr_t s);
        for (int i = 0; i < 10; i++) prob[i] = s[i];
    endtask

    // Push the expectation for a scan whose enable was sampled at edge e.
    task automatic push_exp(input score_arr_t s, input int e);
        logic [3:0]   bi;
        logic [W-1:0] bm;
        ref_argmax(s, bi, bm);
        exp_q.push_back(bi);
        exp_max_q.push_back(bm);
        exp_cyc_q.push_back(e + 9);
    endtask

    // Drive one enable pulse with scores s; returns the sampling edge number.
    task automatic start_scan(input score_arr_t s, output int e);
        set_probs(s);
        argmax_enable = 1'b1;
        @(posedge clk);
        #1;
        e = cyc;
        push_exp(s, e);
        argmax_enable = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq(tag, exp_q.size(), 0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("done_width", {63'd0, prev_done & argmax_done}, 64'd0);
            if (argmax_done) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_done", 1, 0);
                end else begin
                    check_eq("result", result, exp_q.pop_front());
                    check_eq("max_score", max_score, exp_max_q.pop_front());
                    check_eq("done_cycle", cyc, exp_cyc_q.pop_front());
                end
            end
        end
        prev_done <= argmax_done;
    end

    initial begin
        score_arr_t s;
        int e;
        rst = 1'b1;
        argmax_enable = 1'b0;
        for (int i = 0; i < 10; i++) prob[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check_eq("rst_result", result, 0);
        check_eq("rst_max", max_score, 0);
        check_eq("rst_done", argmax_done, 0);
        check_eq("rst_busy", argmax_busy, 0);
        check_eq("rst_state", dbg_state, 0);

        // Basic, with busy window check
        s = '{32'd5, 32'd2, 32'd9, 32'd1, 32'd0, 32'd3, 32'd7, 32'd4, 32'd8, 32'd6};
        start_scan(s, e);
        for (int k = 0; k < 11; k++) begin
            check_eq($sformatf("busy_e%0d", k), argmax_busy, (k < 10) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        wait_drain("basic_drain");
        check_eq("basic_hold_result", result, 2);
        check_eq("basic_hold_max", max_score, 9);

        // Ties and boundary indices
        s = '{default: '0}; s[3] = 100; s[7] = 100;
        start_scan(s, e); wait_drain("tie_drain");
        s = '{default: '0}; s[9] = 1;
        start_scan(s, e); wait_drain("idx9_drain");
        s = '{default: 32'd42};
        start_scan(s, e); wait_drain("equal_drain");

        // Signed extremes
        s = '{default: 32'h8000_0000}; s[4] = 32'hFFFF_FFFF;
        start_scan(s, e); wait_drain("neg_drain");
        s = '{default: 32'h8000_0000}; s[0] = 32'h7FFF_FFFF;
        start_scan(s, e); wait_drain("posmax_drain");
        s = '{default: 32'h8000_0000};
        start_scan(s, e); wait_drain("allmin_drain");

        // Input capture and busy lockout
        s = '{32'd1, 32'd50, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
        start_scan(s, e);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) prob[i] = (i == 6) ? 32'd999 : 32'($urandom_range(0, 20));
        argmax_enable = 1'b1;
        @(posedge clk);
        #1;
        argmax_enable = 1'b0;
        while (cyc < e + 9) begin
            @(posedge clk);
            #1;
        end
        argmax_enable = 1'b1;
        @(posedge clk);
        #1;
        argmax_enable = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check_eq("lockout_drain", exp_q.size(), 0);
        check_eq("lockout_idle", argmax_busy, 0);
        check_eq("lockout_result", result, 1);

        // Reset mid-scan
        s = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd77, 32'd0, 32'd0};
        start_scan(s, e);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete(); exp_max_q.delete(); exp_cyc_q.delete();
        check_eq("midrst_result", result, 0);
        check_eq("midrst_max", max_score, 0);
        check_eq("midrst_busy", argmax_busy, 0);
        repeat (12) @(posedge clk);
        #1;
        check_eq("midrst_no_done_result", result, 0);
        start_scan(s, e); wait_drain("post_rst_drain");

        // Back-to-back with enable held
        s = '{32'd3, 32'd1, 32'd4, 32'd1, 32'd5, 32'd9, 32'd2, 32'd6, 32'd5, 32'd3};
        set_probs(s);
        argmax_enable = 1'b1;
        @(posedge clk);
        #1;
        e = cyc;
        push_exp(s, e);
        repeat (9) @(posedge clk);
        #1;
        s = '{32'hFFFF_FFF0, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd8};
        set_probs(s);
        push_exp(s, e + 11);
        repeat (2) @(posedge clk);
        #1;
        argmax_enable = 1'b0;
        wait_drain("b2b_drain");

        // Random score sets, narrow ranges to provoke ties
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 10; i++) begin
                if (n < 4) s[i] = 32'($signed($urandom_range(0, 6)) - 3);
                else       s[i] = $urandom;
            end
            start_scan(s, e);
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #1;
            wait_drain("rand_drain");
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/argmax_unit.md
# argmax_unit

Final classification stage of the CNN datapath. It captures the ten signed class scores `prob_0`..`prob_9` when `fc_layer` pulses `fc_done`. It scans them sequentially, one comparison per cycle, and drives the winning class index onto the 4-bit `result` output of `top`. It also reports the winning score and a one-cycle completion pulse, which later hand-off or logging stages can use.

## Interface
- `DATA_WIDTH`, default 32: width of each class score, two's-complement signed.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `argmax_enable`  in  1  start strobe; driven by `fc_done`; sampled only in IDLE.
- `prob_0`..`prob_9`  in  `DATA_WIDTH` each  signed class scores; valid in the cycle `argmax_enable` is sampled high.
- `result`  out  4  index (0-9) of the maximum score.
- `max_score`  out  `DATA_WIDTH`  signed value of the winning score.
- `argmax_done`  out  1  one-cycle pulse; `result` and `max_score` are updated in the same cycle.
- `argmax_busy`  out  1  high while a scan is in progress (SCAN or DONE state).

## Operation
- Internal registers:
  - `score[0:9]`, ten `DATA_WIDTH`-bit score copies.
  - `best`, the running maximum score.
  - `best_idx`, 4 bits.
  - `idx`, 4 bits.
  - a 2-bit state register.
- States: IDLE, SCAN, DONE.
- IDLE:
  - On `argmax_enable`=1: capture all ten inputs into `score[]`, set `best`=`prob_0`, `best_idx`=0, `idx`=1, go to SCAN.
  - Inputs are not sampled again after this capture, so upstream may change `prob_*` freely afterwards.
- SCAN, each cycle:
  - If `score[idx]` > `best` (signed, strict), set `best`=`score[idx]` and `best_idx`=`idx`.
  - If `idx`==9, go to DONE. Otherwise increment `idx`.
- Transition into DONE: register `result`=final `best_idx` and `max_score`=final `best`. This includes the idx-9 compare result from the same edge.
- DONE: `argmax_done`=1 for exactly one cycle, then return to IDLE.
- Ties: strict greater-than keeps the earliest index, so the lowest index wins.
- Comparison is full-width signed. 0x80000000 is the most negative value and must never win against any other value.
- No arithmetic is performed, so overflow cannot occur.
- `argmax_enable` in SCAN or DONE is ignored. There is no queueing and no error flag.
- `result` and `max_score` hold their last values until the next DONE; they are never cleared except by reset.
- `argmax_busy` = (state != IDLE).

## Timing
- Reset values:
  - state=IDLE
  - `result`=0
  - `max_score`=0
  - `argmax_done`=0
  - `argmax_busy`=0
  - `idx`=0, `best`=0, `best_idx`=0
- `rst` has priority over `argmax_enable` in the same cycle.
- Reset mid-SCAN or in DONE:
  - aborts the operation in the next cycle;
  - no `argmax_done` pulse is produced;
  - `result` and `max_score` return to 0.
- Latency, with the enable sampled at edge E:
  - `argmax_busy` goes high after E.
  - The compares for idx 1..9 occur at edges E+1..E+9.
  - `argmax_done`=1, plus the new `result` and `max_score`, are visible after edge E+9.
  - `argmax_done` drops and `argmax_busy` drops after edge E+10.
- Throughput: one classification per 11 cycles. The earliest following enable is sampled at edge E+11, i.e. the first cycle back in IDLE; an enable held high there starts a new scan immediately.
- `argmax_done` is never high for two consecutive cycles.

## Test plan
- Basic:
  - Stimulus: scores 0..9 = {5,2,9,1,0,3,7,4,8,6}, enable pulse.
  - Response: `argmax_done` after exactly 9 edges; `result`=2, `max_score`=9; busy high for 10 cycles.
- Tie and boundary index:
  - Stimulus A: `prob_3`=`prob_7`=100, others 0. Response: `result`=3.
  - Stimulus B: the only maximum at `prob_9`=1, others 0. Response: `result`=9.
  - Stimulus C: all equal. Response: `result`=0.
- Signed extremes:
  - Stimulus A: all scores 0x80000000 except `prob_4`=0xFFFFFFFF (-1). Response: `result`=4, `max_score`=0xFFFFFFFF.
  - Stimulus B: `prob_0`=0x7FFFFFFF, `prob_1`=0x80000000. Response: `result`=0.
- Input capture and busy lockout:
  - Stimulus: change all `prob_*` and pulse `argmax_enable` at E+3 and again in the DONE cycle.
  - Response: the result reflects the originally captured scores; only one done pulse is produced; no restart occurs.
- Reset mid-scan:
  - Stimulus: assert `rst` at E+5 for one cycle.
  - Response: no done pulse; `result`=0, `max_score`=0, busy=0. A fresh enable then completes normally with the correct index.
- Back-to-back:
  - Stimulus: enable held continuously with new scores after the first done.
  - Response: the second done arrives exactly 11 cycles after the first, with the correct index for the second score set.
